// File: rtl/vga_scanout_if.sv
// Framebuffer read port shared by vga_scanout (master) and the framebuffer RAM (slave).
interface vga_scanout_if;
   logic [7:0] rd_addr_X;
   logic [6:0] rd_addr_Y;
   logic [2:0] rd_data;

   modport master (output rd_addr_X, output rd_addr_Y, input rd_data);
   modport slave  (input rd_addr_X, input rd_addr_Y, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a 160x120 3-bit framebuffer, each stored pixel shown 4x4.
// Optional colour-bar generator enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic          clock,
   input  logic          resetn,
   vga_scanout_if.master fb,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   input  logic          test_pattern,
`endif
   output logic          vga_clk,
   output logic [7:0]    vga_r,
   output logic [7:0]    vga_g,
   output logic [7:0]    vga_b,
   output logic          hsync_n,
   output logic          vsync_n,
   output logic          blank_n,
   output logic          frame_start
);

   localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

   logic       vga_clk_r;
   logic [9:0] h_count_r;
   logic [9:0] v_count_r;
   logic [9:0] h_next_s;
   logic [9:0] v_next_s;
   logic       tick_s;
   logic       visible_s;
   logic       hsync_s;
   logic       vsync_s;
   logic       first_pixel_s;
   logic [2:0] colour_s;
   logic [2:0] colour_r;
   logic       hsync_n_r;
   logic       vsync_n_r;
   logic       blank_n_r;
   logic       frame_start_r;

   // A tick is the edge where the divided pixel clock falls.
   assign tick_s = vga_clk_r;

   // Raster counter successor values.
   always_comb begin
      h_next_s = h_count_r;
      v_next_s = v_count_r;
      if (h_count_r == H_LAST) begin
         h_next_s = 10'd0;
         if (v_count_r == V_LAST) begin
            v_next_s = 10'd0;
         end else begin
            v_next_s = v_count_r + 10'd1;
         end
      end else begin
         h_next_s = h_count_r + 10'd1;
         v_next_s = v_count_r;
      end
   end

   // Decode of the current counter position into visibility, sync and colour.
   always_comb begin
      visible_s     = (h_count_r < H_VIS) && (v_count_r < V_VIS);
      hsync_s       = (h_count_r >= H_SYNC_LO) && (h_count_r <= H_SYNC_HI);
      vsync_s       = (v_count_r >= V_SYNC_LO) && (v_count_r <= V_SYNC_HI);
      first_pixel_s = (h_count_r == 10'd0) && (v_count_r == 10'd0);
      colour_s      = 3'd0;
      if (visible_s) begin
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         if (test_pattern) begin
            colour_s = h_count_r[9:7];
         end else begin
            colour_s = fb.rd_data;
         end
`else
         colour_s = fb.rd_data;
`endif
      end else begin
         colour_s = 3'd0;
      end
   end

   // Address leads the registered outputs by one pixel so the RAM can answer on the mid-pixel edge.
   assign fb.rd_addr_X = visible_s ? h_count_r[9:2] : 8'd0;
   assign fb.rd_addr_Y = visible_s ? v_count_r[8:2] : 7'd0;

   // Pixel clock divider, raster counters and registered VGA outputs.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         vga_clk_r     <= 1'b0;
         h_count_r     <= 10'd0;
         v_count_r     <= 10'd0;
         hsync_n_r     <= 1'b1;
         vsync_n_r     <= 1'b1;
         blank_n_r     <= 1'b0;
         colour_r      <= 3'd0;
         frame_start_r <= 1'b0;
      end else begin
         vga_clk_r     <= ~vga_clk_r;
         frame_start_r <= tick_s && first_pixel_s;
         if (tick_s) begin
            h_count_r <= h_next_s;
            v_count_r <= v_next_s;
            hsync_n_r <= ~hsync_s;
            vsync_n_r <= ~vsync_s;
            blank_n_r <= visible_s;
            colour_r  <= colour_s;
         end
      end
   end

   assign vga_clk     = vga_clk_r;
   assign vga_r       = {8{colour_r[2]}};
   assign vga_g       = {8{colour_r[1]}};
   assign vga_b       = {8{colour_r[0]}};
   assign hsync_n     = hsync_n_r;
   assign vsync_n     = vsync_n_r;
   assign blank_n     = blank_n_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: raster-index reference model, synchronous RAM model, timing measurements.
module tb_vga_scanout;

   localparam int HV = 640;
   localparam int HF = 16;
   localparam int HS = 96;
   localparam int HB = 48;
   localparam int HT = HV + HF + HS + HB;
   localparam int VV = 16;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 4;
   localparam int VT = VV + VF + VS + VB;
   localparam int FB_W = 160;
   localparam int FB_N = 160 * 120;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       tp = 1'b0;
   logic       vga_clk;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       hsync_n;
   logic       vsync_n;
   logic       blank_n;
   logic       frame_start;

   logic [2:0] ram [0:FB_N-1];

   int total = 0;
   int bad = 0;
   int n = 0;
   int cyc = 0;

   logic p_hs = 1'b1;
   logic p_vs = 1'b1;
   logic p_bl = 1'b0;
   logic p_fs = 1'b0;
   bit   hs_seen = 1'b0;
   bit   vs_seen = 1'b0;
   bit   bl_seen = 1'b0;
   bit   fs_seen = 1'b0;
   int   hs_t = 0;
   int   vs_t = 0;
   int   bl_t = 0;
   int   fs_t = 0;
   int   bursts = 0;

   vga_scanout_if fb();

   vga_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .fb(fb),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      .test_pattern(tp),
`endif
      .vga_clk(vga_clk),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .hsync_n(hsync_n),
      .vsync_n(vsync_n),
      .blank_n(blank_n),
      .frame_start(frame_start)
   );

   always #10 clock = ~clock;

   function automatic logic [2:0] ram_rd(input logic [7:0] x, input logic [6:0] y);
      int i;
      i = int'(y) * FB_W + int'(x);
      return (i < FB_N) ? ram[i] : 3'd0;
   endfunction

   // Framebuffer with a one-clock synchronous read port.
   always @(posedge clock) begin
      fb.rd_data <= ram_rd(fb.rd_addr_X, fb.rd_addr_Y);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // Expected outputs k clock edges after reset release, from the raster pixel index.
   task automatic model(input int k, output logic [4:0] ctl, output logic [23:0] rgb,
                        output logic [14:0] adr);
      int q, p, h, v;
      logic vis;
      logic [2:0] c;
      q = k / 2;
      h = q % HT;
      v = (q / HT) % VT;
      adr = (h < HV && v < VV) ? {8'(h / 4), 7'(v / 4)} : 15'd0;
      ctl = 5'b01100;
      rgb = 24'd0;
      if (k > 0) ctl[4] = (k % 2 == 1);
      if (k >= 2) begin
         p = k / 2 - 1;
         h = p % HT;
         v = (p / HT) % VT;
         vis = (h < HV) && (v < VV);
         if (vis) c = tp ? 3'(h / 128) : ram[(v / 4) * FB_W + h / 4];
         else c = 3'd0;
         ctl[3] = !(h >= HV + HF && h < HV + HF + HS);
         ctl[2] = !(v >= VV + VF && v < VV + VF + VS);
         ctl[1] = vis;
         ctl[0] = (k % 2 == 0) && (p % (HT * VT) == 0);
         rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
      end
   endtask

   task automatic step();
      logic [4:0]  e_ctl;
      logic [23:0] e_rgb;
      logic [14:0] e_adr;
      @(posedge clock);
      cyc++;
      if (!resetn) begin
         n = 0;
         hs_seen = 1'b0;
         vs_seen = 1'b0;
         bl_seen = 1'b0;
         fs_seen = 1'b0;
      end else begin
         n++;
      end
      @(negedge clock);
      model(n, e_ctl, e_rgb, e_adr);
      check_eq("ctl", {27'd0, vga_clk, hsync_n, vsync_n, blank_n, frame_start}, {27'd0, e_ctl});
      check_eq("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, e_rgb});
      check_eq("addr", {17'd0, fb.rd_addr_X, fb.rd_addr_Y}, {17'd0, e_adr});
      if (p_hs && !hsync_n) begin
         if (hs_seen) check_eq("hs_period", 32'(cyc - hs_t), 32'd1600);
         hs_t = cyc;
         hs_seen = 1'b1;
      end
      if (!p_hs && hsync_n && hs_seen) check_eq("hs_width", 32'(cyc - hs_t), 32'd192);
      if (p_vs && !vsync_n) begin
         vs_t = cyc;
         vs_seen = 1'b1;
      end
      if (!p_vs && vsync_n && vs_seen) check_eq("vs_width", 32'(cyc - vs_t), 32'd3200);
      if (!p_fs && frame_start) begin
         if (fs_seen) begin
            check_eq("fs_period", 32'(cyc - fs_t), 32'(2 * HT * VT));
            check_eq("bursts", 32'(bursts), 32'(VV));
         end
         fs_t = cyc;
         fs_seen = 1'b1;
         bursts = 0;
      end
      if (!p_bl && blank_n) begin
         bl_t = cyc;
         bl_seen = 1'b1;
         bursts++;
      end
      if (p_bl && !blank_n && bl_seen) check_eq("blank_width", 32'(cyc - bl_t), 32'd1280);
      p_hs = hsync_n;
      p_vs = vsync_n;
      p_bl = blank_n;
      p_fs = frame_start;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic fill(input logic [2:0] val);
      for (int i = 0; i < FB_N; i++) ram[i] = val;
   endtask

   initial begin
      fill(3'd0);
      ram[3 * FB_W + 5] = 3'b101;
      resetn = 1'b0;
      run(3);
      resetn = 1'b1;
      run(2 * HT * VT + 10 * 2 * HT + int'($urandom_range(0, 1599)));

      resetn = 1'b0;
      fill(3'b111);
      run(3);
      resetn = 1'b1;
      run(4 * 2 * HT + int'($urandom_range(0, 999)));

      resetn = 1'b0;
      for (int i = 0; i < FB_N; i++) ram[i] = 3'($urandom);
      run(3);
      resetn = 1'b1;
      run(5 * 2 * HT + int'($urandom_range(0, 1599)));

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      resetn = 1'b0;
      fill(3'd0);
      tp = 1'b1;
      run(3);
      resetn = 1'b1;
      run(2 * 2 * HT);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
